// File: rtl/q4_lsu.sv
// Q4 load/store stage: drives a req/gnt + rvalid data-memory bus,
// builds byte enables and lane-replicated store data, aligns and
// extends load data, and stalls Q1-Q4 until each access completes.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_valid, i_mem_read,
//   i_mem_write, i_funct3,
//   i_addr, i_store_data    Q3->Q4 register contents
//   o_dmem_*                bus request side (req/we/addr/be/wdata)
//   i_dmem_*                bus response side (gnt/rvalid/rdata)
//   o_load_data, o_done     load result, valid during the done pulse
//   o_stall                 hold pipeline registers Q1-Q4
//   o_misaligned, o_illegal access rejected without bus traffic
module q4_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_done,
    output logic            o_stall,
    output logic            o_misaligned,
    output logic            o_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic            cap_we;
    logic [XLEN-3:0] cap_word;
    logic [3:0]      cap_be;
    logic [XLEN-1:0] cap_wdata;
    logic [2:0]      cap_funct3;
    logic [1:0]      cap_off;
    logic [XLEN-1:0] load_q;

    logic            mem_op;
    logic            bad_f3;
    logic            is_illegal;
    logic            is_misal;
    logic            accept;
    logic            is_b;
    logic            is_h;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext_data;

    // Reset is folded into the request decode so every output reads
    // zero while reset is held, even with a live instruction present.
    assign mem_op = i_valid & (i_mem_read | i_mem_write) & ~i_rst;
    assign bad_f3 = (i_funct3 == 3'b011) | (i_funct3[2] & i_funct3[1]);
    assign is_illegal = mem_op & (bad_f3 | (i_mem_read & i_mem_write));

    assign is_b = (i_funct3[1:0] == 2'b00);
    assign is_h = (i_funct3[1:0] == 2'b01);

    assign is_misal = mem_op & ~is_illegal &
                      ((is_h & i_addr[0]) |
                       (i_funct3[1:0] == 2'b10 & |i_addr[1:0]));

    assign accept = mem_op & ~is_illegal & ~is_misal;

    always_comb begin
        be_n    = 4'hF;
        wdata_n = i_store_data;
        unique case (1'b1)
            is_b: begin
                be_n    = 4'b0001 << i_addr[1:0];
                wdata_n = {4{i_store_data[7:0]}};
            end
            is_h: begin
                be_n    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_n = {2{i_store_data[15:0]}};
            end
            default: begin
                be_n    = 4'hF;
                wdata_n = i_store_data;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend by size/sign.
    assign shifted = i_dmem_rdata >> {cap_off, 3'b000};

    always_comb begin
        ext_data = shifted;
        unique case (1'b1)
            cap_funct3[1:0] == 2'b00:
                ext_data = {{24{shifted[7] & ~cap_funct3[2]}},
                            shifted[7:0]};
            cap_funct3[1:0] == 2'b01:
                ext_data = {{16{shifted[15] & ~cap_funct3[2]}},
                            shifted[15:0]};
            default:
                ext_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        o_dmem_req   = 1'b0;
        o_done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_illegal    = is_illegal;
                o_misaligned = is_misal;
                o_stall      = accept;
                if (accept) state_d = S_REQ;
            end
            S_REQ: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                if (i_dmem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) state_d = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cap_we     <= 1'b0;
            cap_word   <= '0;
            cap_be     <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
            cap_off    <= '0;
            load_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && accept) begin
                cap_we     <= i_mem_write;
                cap_word   <= i_addr[XLEN-1:2];
                cap_be     <= be_n;
                cap_wdata  <= wdata_n;
                cap_funct3 <= i_funct3;
                cap_off    <= i_addr[1:0];
            end
            if (state_q == S_WAIT && i_dmem_rvalid) begin
                load_q <= cap_we ? '0 : ext_data;
            end
        end
    end

    assign o_dmem_we    = cap_we;
    assign o_dmem_addr  = {cap_word, 2'b00};
    assign o_dmem_be    = cap_be;
    assign o_dmem_wdata = cap_wdata;
    assign o_load_data  = load_q;

endmodule

// File: doc/q4_lsu.md
Name: q4_lsu

Overview:
- Q4 memory-access stage: consumes the Q3→Q4 pipeline register outputs and performs load/store transfers on a 32-bit data-memory bus with a req/gnt + rvalid handshake.
- Generates byte enables and store-data replication; aligns and sign/zero-extends load data.
- Holds the pipeline behind it via o_stall until each transfer completes.
- Produces the load result consumed by the Q4→Q5 register and reports misaligned/illegal accesses.

Parameters:
- XLEN, 32, datapath width (only 32 supported)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_valid  in  1  Q3→Q4 register holds a live instruction (0 for bubble/NOP)
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_funct3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- i_addr  in  32  effective address (ALU result)
- i_store_data  in  32  rs2 data
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  response (load data or store ack)
- i_dmem_rdata  in  32  response data
- o_load_data  out  32  aligned, extended load result; valid when o_done=1
- o_done  out  1  one-cycle pulse: access complete
- o_stall  out  1  hold Q1–Q4 registers
- o_misaligned  out  1  one-cycle pulse: misaligned access, no bus traffic
- o_illegal  out  1  one-cycle pulse: bad funct3, or read and write both set

Behaviour:
- Reset (async, any state): FSM→IDLE; all outputs 0; captured registers 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- Memory op = i_valid & (i_mem_read | i_mem_write).

IDLE:
- Non-memory op or bubble: no action, o_stall=0.
- Legal, aligned memory op: o_stall=1 (combinational) this cycle; capture we, word address, be, wdata, funct3, addr[1:0]; →REQ.
- Misaligned (h/hu/sh with addr[0]=1; w with addr[1:0]≠0): o_misaligned=1 for one cycle; no stall; stay in IDLE.
- Illegal (funct3 011/110/111, or read&write both set): o_illegal=1 for one cycle; no stall; stay in IDLE. Illegal takes priority over misaligned.

REQ:
- o_dmem_req=1 with captured fields; fields stable until gnt; o_stall=1.
- On i_dmem_gnt: →WAIT.

WAIT:
- o_dmem_req=0; o_stall=1.
- On i_dmem_rvalid: register the extended load data (stores: register 0); →DONE.

DONE:
- o_done=1, o_stall=0, o_load_data valid.
- Inputs are ignored (same instruction is still presented); →IDLE unconditionally.
- Q4→Q5 captures at the end of DONE.

Timing:
- Minimum latency, gnt in the first REQ cycle and rvalid the next cycle: 4 cycles from IDLE accept to end of DONE.
- Stall cycles = 3 + gnt wait + rvalid wait.

Responses:
- i_dmem_rvalid outside WAIT is ignored; this includes late responses after a reset.
- rvalid in the same cycle as gnt is not supported: the bus guarantees rvalid ≥1 cycle after gnt.

Store encoding:
- sb: be = 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
- sh: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{data[15:0]}}.
- sw: be = 4'hF, wdata = data.

Load extraction:
- Select the byte/halfword from rdata at the captured addr[1:0].
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes rdata through.

Test Plan:
- lw addr 0x100, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF → req/we=0/be=F/addr=0x100; o_stall high 3 cycles; DONE cycle o_load_data=0xDEADBEEF, o_done=1.
- lb addr 0x203, rdata 0x80112233 → be=4'b1000, o_load_data=0xFFFFFF80. Same with lbu → 0x00000080. lhu addr 0x202 → 0x00008011.
- sh addr 0x306, data 0x0000ABCD, gnt held off 3 cycles → req and fields stable for 4 REQ cycles; be=4'b1100; wdata=0xABCDABCD; o_done after ack.
- lw addr 0x101 → o_misaligned pulse, no o_dmem_req, no o_stall. funct3=011 with read → o_illegal pulse only.
- Assert i_rst during WAIT, then rvalid arrives after reset release → FSM IDLE, outputs 0, response ignored, no o_done.
- Back-to-back sw 0x10 then lw 0x10 with 1-cycle bus → second access starts only after DONE of first; no duplicate request for the first.
